// File: rtl/sdram_bridge_scheduler_if.sv
// Bundle of signals between the requesters, the scheduler and the 128-bit SDRAM bridge.
// The scheduler connects through the slave modport. The requester/bridge side connects through the master modport.
interface sdram_bridge_scheduler_if #(
  parameter int NUM_REQ = 4
);
  // Requester side
  logic [NUM_REQ-1:0]     req_rd;
  logic [NUM_REQ-1:0]     req_wr;
  logic [NUM_REQ-1:0]     req_lock;
  logic [NUM_REQ*22-1:0]  req_addr;
  logic [NUM_REQ*128-1:0] req_wrdata;
  logic [NUM_REQ*16-1:0]  req_be;
  logic [NUM_REQ-1:0]     req_wait;
  logic [NUM_REQ-1:0]     req_ac;
  logic [127:0]           req_rddata;

  // Bridge side
  logic [25:0]            bridge_address;
  logic [15:0]            bridge_byte_enable;
  logic                   bridge_read;
  logic                   bridge_write;
  logic [127:0]           bridge_write_data;
  logic                   bridge_acknowledge;
  logic [127:0]           bridge_read_data;

  modport slave (
    input  req_rd, req_wr, req_lock, req_addr, req_wrdata, req_be,
    input  bridge_acknowledge, bridge_read_data,
    output req_wait, req_ac, req_rddata,
    output bridge_address, bridge_byte_enable, bridge_read, bridge_write, bridge_write_data
  );

  modport master (
    output req_rd, req_wr, req_lock, req_addr, req_wrdata, req_be,
    output bridge_acknowledge, bridge_read_data,
    input  req_wait, req_ac, req_rddata,
    input  bridge_address, bridge_byte_enable, bridge_read, bridge_write, bridge_write_data
  );
endinterface

// File: rtl/sdram_bridge_scheduler.sv
// Shares the single 128-bit SDRAM bridge port among NUM_REQ requesters.
// Until SD init is done, only INIT_IDX is served. After that, URGENT_IDX (audio) has strict priority.
// The other requesters are served round-robin, and a requester may hold a bounded burst lock.
// A sticky flag reports any bridge operation that waits too long for its acknowledge.
module sdram_bridge_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int INIT_IDX   = 0,
  parameter int URGENT_IDX = 2,
  parameter int MAX_BURST  = 8,
  parameter int TIMEOUT    = 4095
) (
  input  logic clk,
  input  logic reset_n,
  input  logic init_done,
  output logic timeout_err,
  sdram_bridge_scheduler_if.slave bus
);

  localparam int                 IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int                 TO_W        = $clog2(TIMEOUT + 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0    = NUM_REQ'(1);
  localparam logic [NUM_REQ-1:0] INIT_MASK   = ONE_HOT0 << INIT_IDX;
  localparam logic [IDX_W-1:0]   URGENT_L    = IDX_W'(URGENT_IDX);
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_REQ - 1);
  localparam logic [7:0]         MAX_BURST_L = 8'(MAX_BURST);
  localparam logic [TO_W-1:0]    TO_LAST     = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     winner_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     lock_idx_q;
  logic                 lock_valid_q;
  logic [7:0]           burst_cnt_q;
  logic [TO_W-1:0]      to_cnt_q;
  logic                 timeout_err_q;
  logic                 bridge_read_q;
  logic                 bridge_write_q;
  logic [25:0]          addr_q;
  logic [127:0]         wdata_q;
  logic [15:0]          be_q;
  logic [NUM_REQ-1:0]   req_wait_q;
  logic [NUM_REQ-1:0]   req_ac_q;
  logic [127:0]         rddata_q;

  logic [NUM_REQ-1:0]   eligible;
  logic                 lock_ok;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     cand;
  logic                 sel_rd;
  logic                 sel_wr;
  logic [21:0]          sel_addr;
  logic [127:0]         sel_wdata;
  logic [15:0]          sel_be;

  // Choose the next winner: a locked holder first, then audio, then round-robin after the last served requester.
  always_comb begin
    eligible = bus.req_rd | bus.req_wr;
    if (!init_done) begin
      eligible = eligible & INIT_MASK;
    end
    lock_ok = lock_valid_q && (burst_cnt_q < MAX_BURST_L) && eligible[lock_idx_q] &&
              !(eligible[URGENT_IDX] && (lock_idx_q != URGENT_L));
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    if (lock_ok) begin
      pick_valid = 1'b1;
      pick_idx   = lock_idx_q;
    end else if (eligible[URGENT_IDX]) begin
      pick_valid = 1'b1;
      pick_idx   = URGENT_L;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
        if (!pick_valid && eligible[cand]) begin
          pick_valid = 1'b1;
          pick_idx   = cand;
        end
      end
    end
  end

  // Route the candidate winner's command, address, data and byte enables to the bridge registers.
  always_comb begin
    sel_rd    = 1'b0;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_rd    = bus.req_rd[i];
        sel_wr    = bus.req_wr[i];
        sel_addr  = bus.req_addr[22*i +: 22];
        sel_wdata = bus.req_wrdata[128*i +: 128];
        sel_be    = bus.req_be[16*i +: 16];
      end
    end
  end

  // Scheduler FSM: latch a winner, hold the bridge strobe until ack, then pulse completion and update arbitration state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      winner_q       <= '0;
      rr_ptr_q       <= LAST_IDX;
      lock_idx_q     <= '0;
      lock_valid_q   <= 1'b0;
      burst_cnt_q    <= '0;
      to_cnt_q       <= '0;
      timeout_err_q  <= 1'b0;
      bridge_read_q  <= 1'b0;
      bridge_write_q <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      be_q           <= '0;
      req_wait_q     <= '1;
      req_ac_q       <= '0;
      rddata_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q        <= ISSUE;
            winner_q       <= pick_idx;
            bridge_write_q <= sel_wr;
            bridge_read_q  <= sel_rd & ~sel_wr;
            addr_q         <= {sel_addr, 4'b0000};
            wdata_q        <= sel_wdata;
            be_q           <= sel_be;
            req_wait_q     <= ~(ONE_HOT0 << pick_idx);
            to_cnt_q       <= '0;
          end
        end
        ISSUE: begin
          if (bus.bridge_acknowledge) begin
            state_q        <= DONE;
            bridge_read_q  <= 1'b0;
            bridge_write_q <= 1'b0;
            req_ac_q       <= ONE_HOT0 << winner_q;
            rddata_q       <= bus.bridge_read_data;
          end else begin
            if (to_cnt_q == TO_LAST) begin
              timeout_err_q <= 1'b1;
            end else begin
              to_cnt_q <= to_cnt_q + TO_W'(1);
            end
          end
        end
        DONE: begin
          state_q      <= IDLE;
          req_ac_q     <= '0;
          req_wait_q   <= '1;
          if (winner_q != URGENT_L) begin
            rr_ptr_q <= winner_q;
          end
          lock_idx_q   <= winner_q;
          lock_valid_q <= bus.req_lock[winner_q];
          if (!bus.req_lock[winner_q]) begin
            burst_cnt_q <= '0;
          end else if (winner_q != lock_idx_q) begin
            burst_cnt_q <= 8'd1;
          end else if (burst_cnt_q != 8'hFF) begin
            burst_cnt_q <= burst_cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.bridge_read        = bridge_read_q;
  assign bus.bridge_write       = bridge_write_q;
  assign bus.bridge_address     = addr_q;
  assign bus.bridge_write_data  = wdata_q;
  assign bus.bridge_byte_enable = be_q;
  assign bus.req_wait           = req_wait_q;
  assign bus.req_ac             = req_ac_q;
  assign bus.req_rddata         = rddata_q;
  assign timeout_err            = timeout_err_q;

endmodule

// File: tb/tb_sdram_bridge_scheduler.sv
// Testbench for sdram_bridge_scheduler: requester agents plus a bridge responder, with an expected-grant scoreboard.
module tb_sdram_bridge_scheduler;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 4095;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic init_done = 1'b0;
  logic timeout_err;

  sdram_bridge_scheduler_if #(.NUM_REQ(NUM_REQ)) bus();

  sdram_bridge_scheduler #(
    .NUM_REQ(NUM_REQ), .INIT_IDX(0), .URGENT_IDX(2), .MAX_BURST(8), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .init_done(init_done), .timeout_err(timeout_err), .bus(bus)
  );

  // 50 MHz clock
  always #10 clk = ~clk;

  int           nChecks = 0;
  int           nBad = 0;
  int           expGrant[$];
  logic [127:0] expRd[$];
  int           opsLeft[NUM_REQ];
  int           opsDone[NUM_REQ];
  bit           opActive, ackHigh, holdAck, useFixed;
  int           ackDelay, waitLeft, opCycles, curIdx;
  int           trigIdx, trigCount, trigTarget;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nChecks++;
    if (got !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input bit rd, input bit wr, input bit lock, input int ops);
    bus.req_rd[idx]   = rd;
    bus.req_wr[idx]   = wr;
    bus.req_lock[idx] = lock;
    opsLeft[idx]      = ops;
  endtask

  task automatic applyReset();
    reset_n = 1'b0;
    bus.req_rd = '0;
    bus.req_wr = '0;
    bus.req_lock = '0;
    bus.bridge_acknowledge = 1'b0;
    expGrant.delete();
    expRd.delete();
    opActive = 0; ackHigh = 0; holdAck = 0; useFixed = 0;
    ackDelay = 0; waitLeft = 0; opCycles = 0; curIdx = -1; trigIdx = -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      opsLeft[i] = 0;
      opsDone[i] = 0;
    end
    repeat (2) @(negedge clk);
    checkOutput("reset read", bus.bridge_read, 0);
    checkOutput("reset write", bus.bridge_write, 0);
    checkOutput("reset addr", bus.bridge_address, 0);
    checkOutput("reset wait", bus.req_wait, 4'hF);
    checkOutput("reset ac", bus.req_ac, 0);
    checkOutput("reset rddata", bus.req_rddata, 0);
    checkOutput("reset err", timeout_err, 0);
    reset_n = 1'b1;
  endtask

  // A new bridge operation appeared: compare it with the next expected grant
  task automatic startOp();
    logic [NUM_REQ-1:0] waitExp;
    logic               wrExp, rdExp;
    logic [25:0]        addrExp;
    if (expGrant.size() == 0) begin
      checkOutput("unexpected op", 1, 0);
      curIdx = -1;
    end else begin
      curIdx  = expGrant.pop_front();
      wrExp   = bus.req_wr[curIdx];
      rdExp   = bus.req_rd[curIdx] & ~wrExp;
      addrExp = {bus.req_addr[22*curIdx +: 22], 4'b0000};
      waitExp = ~(NUM_REQ'(1) << curIdx);
      checkOutput("grant addr", bus.bridge_address, addrExp);
      checkOutput("grant write", bus.bridge_write, wrExp);
      checkOutput("grant read", bus.bridge_read, rdExp);
      checkOutput("grant be", bus.bridge_byte_enable, bus.req_be[16*curIdx +: 16]);
      checkOutput("grant wait", bus.req_wait, waitExp);
      if (wrExp) checkOutput("grant wdata", bus.bridge_write_data, bus.req_wrdata[128*curIdx +: 128]);
    end
  endtask

  // Completion pulse: check the target and the data, then let the requester retire or continue
  task automatic handleAc();
    logic [NUM_REQ-1:0] mask;
    mask = (curIdx >= 0) ? (NUM_REQ'(1) << curIdx) : '0;
    checkOutput("ac onehot", bus.req_ac, mask);
    if (expRd.size() > 0) checkOutput("rddata", bus.req_rddata, expRd.pop_front());
    else checkOutput("spurious ac", 1, 0);
    if (curIdx >= 0) begin
      opsDone[curIdx]++;
      opsLeft[curIdx]--;
      if (opsLeft[curIdx] <= 0) applyStimulus(curIdx, 0, 0, 0, 0);
      if (curIdx == trigIdx && opsDone[curIdx] == trigCount) begin
        applyStimulus(trigTarget, 1, 0, 0, 1);
        trigIdx = -1;
      end
    end
  endtask

  // One clock of the bench: everything is sampled and driven at the falling edge
  task automatic cycleStep();
    logic [127:0] rdata;
    @(negedge clk);
    if (ackHigh) begin
      bus.bridge_acknowledge = 1'b0;
      ackHigh  = 0;
      opActive = 0;
    end
    if (bus.req_ac != 0) handleAc();
    if (bus.bridge_read || bus.bridge_write) begin
      if (!opActive) begin
        startOp();
        opActive = 1;
        waitLeft = ackDelay;
        opCycles = 0;
      end else begin
        opCycles++;
      end
      if (!holdAck) begin
        if (waitLeft == 0) begin
          rdata = useFixed ? 128'hDEAD_0123_4567_89AB_CDEF_7654_3210_BEEF
                           : {$urandom, $urandom, $urandom, $urandom};
          useFixed = 0;
          bus.bridge_read_data   = rdata;
          bus.bridge_acknowledge = 1'b1;
          ackHigh = 1;
          expRd.push_back(rdata);
        end else begin
          waitLeft--;
        end
      end
    end
  endtask

  task automatic runUntilDone(input int maxCycles);
    int n = 0;
    while ((expGrant.size() != 0 || opActive || expRd.size() != 0) && n < maxCycles) begin
      cycleStep();
      n++;
    end
    checkOutput("drain within budget", n < maxCycles, 1);
    repeat (6) cycleStep();
    checkOutput("idle strobes", {bus.bridge_read, bus.bridge_write}, 0);
    checkOutput("idle wait", bus.req_wait, 4'hF);
  endtask

  initial begin
    int n;
    bus.bridge_read_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_addr[22*i +: 22]     = 22'((i + 1) * 4096 + 16 * i + 5);
      bus.req_wrdata[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
      bus.req_be[16*i +: 16]       = 16'($urandom);
    end

    // Init gating: only requester 0 (a write to word 0x10) may go while init_done is low
    init_done = 1'b0;
    applyReset();
    bus.req_addr[21:0] = 22'h000010;
    applyStimulus(0, 0, 1, 0, 1);
    applyStimulus(1, 1, 0, 0, 1);
    applyStimulus(2, 1, 0, 0, 1);
    applyStimulus(3, 1, 0, 0, 1);
    expGrant.push_back(0);
    runUntilDone(100);
    repeat (10) cycleStep();
    checkOutput("init gate strobes", {bus.bridge_read, bus.bridge_write}, 0);
    init_done = 1'b1;
    expGrant = '{2, 1, 3};
    runUntilDone(100);

    // Audio priority, then round-robin with wrap
    applyReset();
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 1, 0, 0, (i == 2) ? 3 : 2);
    expGrant = '{2, 2, 2, 0, 1, 3, 0, 1, 3};
    runUntilDone(200);

    // Burst lock is capped at eight consecutive grants
    applyReset();
    applyStimulus(1, 1, 0, 1, 12);
    applyStimulus(3, 1, 0, 0, 1);
    expGrant = '{1, 1, 1, 1, 1, 1, 1, 1, 3, 1, 1, 1, 1};
    runUntilDone(300);

    // Audio preempts a locked burst, then the burst resumes
    applyReset();
    applyStimulus(1, 1, 0, 1, 6);
    trigIdx = 1; trigCount = 3; trigTarget = 2;
    expGrant = '{1, 1, 1, 2, 1, 1, 1};
    runUntilDone(200);

    // Slow acknowledge, fixed read pattern, and write winning over read
    applyReset();
    ackDelay = 2;
    useFixed = 1;
    applyStimulus(0, 1, 1, 0, 1);
    applyStimulus(3, 1, 0, 0, 2);
    expGrant = '{0, 3, 3};
    runUntilDone(200);

    // Timeout boundary, sticky flag, and reset abandoning an op
    applyReset();
    applyStimulus(3, 1, 0, 0, 1);
    expGrant.push_back(3);
    holdAck = 1;
    n = 0;
    while (!opActive && n < 50) begin cycleStep(); n++; end
    while (opCycles < TIMEOUT - 1 && n < TIMEOUT + 100) begin cycleStep(); n++; end
    checkOutput("err before limit", timeout_err, 0);
    cycleStep();
    checkOutput("err at limit", timeout_err, 1);
    checkOutput("strobe held", bus.bridge_read, 1);
    holdAck = 0;
    runUntilDone(50);
    checkOutput("err sticky", timeout_err, 1);
    applyStimulus(0, 1, 0, 0, 1);
    expGrant.push_back(0);
    holdAck = 1;
    n = 0;
    while (!opActive && n < 50) begin cycleStep(); n++; end
    repeat (3) cycleStep();
    #3 reset_n = 1'b0;
    #1;
    checkOutput("async reset read", bus.bridge_read, 0);
    checkOutput("async reset err", timeout_err, 0);
    checkOutput("async reset wait", bus.req_wait, 4'hF);
    applyReset();

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
